// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch (IF) and load/store (D),
// one transaction at a time. Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_SIZE_BYTE = 2'd0,
        MEM_ACCESS_SIZE_HALF = 2'd1,
        MEM_ACCESS_SIZE_WORD = 2'd2
    } mem_access_size_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [31:0]      if_rdata_o,
    output logic             if_err_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [31:0]      d_addr_i,
    input  logic [31:0]      d_wdata_i,
    input  mem_access_size_t d_size_i,
    output logic             d_gnt_o,
    output logic             d_rvalid_o,
    output logic [31:0]      d_rdata_o,
    output logic             d_err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output mem_access_size_t mem_size_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i
);
    localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} port_t;

    state_t           state_q, state_d;
    port_t            owner_q, owner_d;
    port_t            winner;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    mem_access_size_t mem_size_q, mem_size_d;
    logic             gnt, fin, fin_err;
    logic [31:0]      fin_data;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    port_t            last_q, last_d;
`endif

    always_comb begin
        winner = OWN_IF;
        if (if_req_i && d_req_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            winner = (last_q == OWN_IF) ? OWN_D : OWN_IF;
`else
            winner = OWN_D;
`endif
        end else if (d_req_i) begin
            winner = OWN_D;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        gnt         = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_data    = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (if_req_i || d_req_i) begin
                    gnt     = 1'b1;
                    owner_d = winner;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                    if (winner == OWN_D) begin
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        mem_size_d  = d_size_i;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        mem_size_d  = MEM_ACCESS_SIZE_WORD;
                    end
                end
            end
            ST_ISSUE: begin
                if (cnt_q == CNT_MAX) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mem_gnt_i) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion arriving on the watchdog's last cycle still counts as good.
                if (mem_rvalid_i) begin
                    fin      = 1'b1;
                    fin_data = mem_rdata_i;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= MEM_ACCESS_SIZE_WORD;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q      <= OWN_IF;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    // Handshake pulses are masked while reset is held so a grant is never left without its completion.
    assign if_gnt_o    = gnt && (winner == OWN_IF) && !reset_i;
    assign d_gnt_o     = gnt && (winner == OWN_D) && !reset_i;
    assign if_rvalid_o = fin && (owner_q == OWN_IF) && !reset_i;
    assign d_rvalid_o  = fin && (owner_q == OWN_D) && !reset_i;
    assign if_err_o    = if_rvalid_o && fin_err;
    assign d_err_o     = d_rvalid_o && fin_err;
    assign if_rdata_o  = if_rvalid_o ? fin_data : '0;
    assign d_rdata_o   = d_rvalid_o ? fin_data : '0;

    assign mem_req_o   = (state_q == ST_ISSUE);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_size_o  = mem_size_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MW = 8;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             if_req_i = 1'b0;
    logic [31:0]      if_addr_i = '0;
    logic             if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0]      if_rdata_o;
    logic             d_req_i = 1'b0;
    logic             d_we_i = 1'b0;
    logic [31:0]      d_addr_i = '0;
    logic [31:0]      d_wdata_i = '0;
    mem_access_size_t d_size_i = MEM_ACCESS_SIZE_WORD;
    logic             d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0]      d_rdata_o;
    logic             mem_req_o, mem_we_o;
    logic [31:0]      mem_addr_o, mem_wdata_o;
    mem_access_size_t mem_size_o;
    logic             mem_gnt_i = 1'b0;
    logic             mem_rvalid_i = 1'b0;
    logic [31:0]      mem_rdata_i = '0;

    int n_tests = 0;
    int n_fails = 0;

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_size_i(d_size_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Reference model: one open transaction, tracked by elapsed cycles since its grant.
    bit               m_busy = 0;
    bit               m_owner_d = 0;
    bit               m_acc = 0;
    bit               m_lw_d = 0;
    int               m_t = 0;
    logic [31:0]      m_addr = '0;
    logic [31:0]      m_wdata = '0;
    bit               m_we = 0;
    mem_access_size_t m_size = MEM_ACCESS_SIZE_WORD;

    logic        obs_if_gnt, obs_d_gnt, obs_if_rv, obs_d_rv, obs_if_err, obs_d_err, obs_mem_req, obs_mem_we;
    logic [31:0] obs_if_rdata, obs_d_rdata, obs_mem_addr, obs_mem_wdata, obs_mem_size;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pick_d(input bit ifr, input bit dr, input bit lw_d);
        if (ifr && dr) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            return !lw_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic model_check();
        logic        e_ifg, e_dg, e_ifv, e_dv, e_ife, e_de, e_req;
        logic [31:0] e_ifd, e_dd;
        bit          any, win_d, ok, ab;
        e_ifg = 0; e_dg = 0; e_ifv = 0; e_dv = 0; e_ife = 0; e_de = 0;
        e_ifd = '0; e_dd = '0;
        ok = 0; ab = 0;
        any   = if_req_i || d_req_i;
        win_d = pick_d(if_req_i, d_req_i, m_lw_d);
        e_req = m_busy && !m_acc;
        if (!reset_i) begin
            if (!m_busy) begin
                if (any) begin
                    e_dg  = win_d;
                    e_ifg = !win_d;
                end
            end else begin
                ok = m_acc && mem_rvalid_i;
                ab = !ok && (m_t == MW + 1);
                if (m_owner_d) begin
                    e_dv = ok || ab; e_de = ab; e_dd = ok ? mem_rdata_i : 32'h0;
                end else begin
                    e_ifv = ok || ab; e_ife = ab; e_ifd = ok ? mem_rdata_i : 32'h0;
                end
            end
        end
        obs_if_gnt = if_gnt_o;     obs_d_gnt = d_gnt_o;
        obs_if_rv = if_rvalid_o;   obs_d_rv = d_rvalid_o;
        obs_if_err = if_err_o;     obs_d_err = d_err_o;
        obs_if_rdata = if_rdata_o; obs_d_rdata = d_rdata_o;
        obs_mem_req = mem_req_o;   obs_mem_we = mem_we_o;
        obs_mem_addr = mem_addr_o; obs_mem_wdata = mem_wdata_o;
        obs_mem_size = 32'(mem_size_o);
        chk("if_gnt", obs_if_gnt, e_ifg);
        chk("d_gnt", obs_d_gnt, e_dg);
        chk("if_rvalid", obs_if_rv, e_ifv);
        chk("d_rvalid", obs_d_rv, e_dv);
        chk("if_err", obs_if_err, e_ife);
        chk("d_err", obs_d_err, e_de);
        chk("if_rdata", obs_if_rdata, e_ifd);
        chk("d_rdata", obs_d_rdata, e_dd);
        chk("mem_req", obs_mem_req, e_req);
        chk("mem_we", obs_mem_we, m_we);
        chk("mem_addr", obs_mem_addr, m_addr);
        chk("mem_wdata", obs_mem_wdata, m_wdata);
        chk("mem_size", obs_mem_size, 32'(m_size));
        if (reset_i) begin
            m_busy = 0; m_acc = 0; m_t = 0; m_lw_d = 0; m_owner_d = 0;
            m_addr = '0; m_wdata = '0; m_we = 0; m_size = MEM_ACCESS_SIZE_WORD;
        end else if (!m_busy) begin
            if (any) begin
                m_busy = 1; m_acc = 0; m_t = 1; m_owner_d = win_d; m_lw_d = win_d;
                if (win_d) begin
                    m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i; m_size = d_size_i;
                end else begin
                    m_addr = if_addr_i; m_we = 0; m_wdata = '0; m_size = MEM_ACCESS_SIZE_WORD;
                end
            end
        end else if (ok || ab) begin
            m_busy = 0;
        end else begin
            if (!m_acc && mem_gnt_i) m_acc = 1;
            m_t++;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq;
        logic [3:0] exp_seq;
        int         ng;
        int         nreq;
        int         first;

        @(posedge clk);
        #1;
        cyc();
        chk("reset_mem_size", obs_mem_size, 32'(MEM_ACCESS_SIZE_WORD));
        chk("reset_mem_addr", obs_mem_addr, 32'h0);
        cyc();
        reset_i = 1'b0;
        cyc();
        chk("idle_mem_req", obs_mem_req, 1'b0);

        // single fetch
        if_req_i = 1; if_addr_i = 32'h100;
        cyc(); chk("fetch_gnt", obs_if_gnt, 1'b1);
        if_req_i = 0; if_addr_i = 32'h0; mem_gnt_i = 1;
        cyc(); chk("fetch_mem_req", obs_mem_req, 1'b1);
        chk("fetch_mem_addr", obs_mem_addr, 32'h100);
        chk("fetch_mem_size", obs_mem_size, 32'(MEM_ACCESS_SIZE_WORD));
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
        cyc(); chk("fetch_rvalid", obs_if_rv, 1'b1);
        chk("fetch_rdata", obs_if_rdata, 32'h0000_0013);
        chk("fetch_err", obs_if_err, 1'b0);
        mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc(); chk("fetch_done_req", obs_mem_req, 1'b0);

        // store with a slow bus grant
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'h1122_3344;
        d_size_i = MEM_ACCESS_SIZE_BYTE;
        cyc(); chk("store_gnt", obs_d_gnt, 1'b1);
        d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_size_i = MEM_ACCESS_SIZE_WORD;
        nreq = 0;
        for (int k = 0; k < 4; k++) begin
            mem_gnt_i = (k == 3);
            cyc();
            nreq += int'(obs_mem_req);
            chk("store_addr", obs_mem_addr, 32'h2000);
            chk("store_wdata", obs_mem_wdata, 32'h1122_3344);
            chk("store_we", obs_mem_we, 1'b1);
            chk("store_size", obs_mem_size, 32'(MEM_ACCESS_SIZE_BYTE));
        end
        chk("store_req_cycles", 32'(nreq), 32'd4);
        mem_gnt_i = 0; mem_rvalid_i = 1;
        cyc(); chk("store_rvalid", obs_d_rv, 1'b1);
        chk("store_err", obs_d_err, 1'b0);
        mem_rvalid_i = 0;
        cyc();

        // tie: both ports request continuously, bus always ready
        reset_i = 1;
        cyc();
        reset_i = 0;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0000;
        if_addr_i = 32'h200; d_addr_i = 32'h300;
        seq = '0; ng = 0;
        for (int k = 0; k < 12; k++) begin
            if_req_i = (k <= 9);
            d_req_i  = (k <= 9);
            cyc();
            if (obs_d_gnt || obs_if_gnt) begin
                seq = {seq[2:0], obs_d_gnt};
                ng++;
            end
        end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        chk("tie_grants", 32'(ng), 32'd4);
        chk("tie_order", 32'(seq), 32'(exp_seq));
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        if_addr_i = '0; d_addr_i = '0;
        cyc();

        // watchdog: bus never grants
        d_req_i = 1; d_addr_i = 32'h3000; mem_rdata_i = 32'hDEAD_BEEF;
        cyc(); chk("wd_gnt", obs_d_gnt, 1'b1);
        d_req_i = 0; d_addr_i = '0;
        first = -1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (obs_d_rv && first < 0) begin
                first = k;
                chk("wd_err", obs_d_err, 1'b1);
                chk("wd_rdata", obs_d_rdata, 32'h0);
            end
        end
        chk("wd_cycle", 32'(first), 32'd9);
        mem_rvalid_i = 1;
        cyc(); chk("wd_late_rvalid", obs_d_rv, 1'b0);
        chk("wd_idle_req", obs_mem_req, 1'b0);
        mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc();

        // reset in the middle of a fetch, then a clean fetch
        if_req_i = 1; if_addr_i = 32'h400;
        cyc(); chk("rst_gnt", obs_if_gnt, 1'b1);
        if_req_i = 0; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; reset_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        cyc(); chk("rst_no_rvalid", obs_if_rv, 1'b0);
        reset_i = 0;
        cyc(); chk("rst_req_low", obs_mem_req, 1'b0);
        chk("rst_dropped_rvalid", obs_if_rv, 1'b0);
        mem_rvalid_i = 0; mem_rdata_i = '0;
        if_req_i = 1; if_addr_i = 32'h104;
        cyc(); chk("refetch_gnt", obs_if_gnt, 1'b1);
        if_req_i = 0; mem_gnt_i = 1;
        cyc(); chk("refetch_addr", obs_mem_addr, 32'h104);
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0010_0093;
        cyc(); chk("refetch_rdata", obs_if_rdata, 32'h0010_0093);
        chk("refetch_rvalid", obs_if_rv, 1'b1);
        mem_rvalid_i = 0; mem_rdata_i = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
